// File: rtl/pipeline_stall_ctrl.sv
// Purpose: hazard/sequencing controller driving clock enables and bubble flushes for the 5-stage pipeline.
// Latency: enables/flushes are combinational from state and inputs; state advances on Tick-qualified Clock edges.
// Backpressure: mul/div, load-use and drain/halt freeze the upstream stages; Tick=0 freezes everything.
module pipeline_stall_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MULDIV_LAT  = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   ex_memread,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_branch_taken,
  input  logic                   ex_muldiv,
  input  logic                   halt_req,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] HALTED  = 2'd3;

  // The start cycle is one of the MULDIV_LAT stall cycles, so MD_BUSY runs for MULDIV_LAT-1 cycles.
  localparam logic [7:0] MD_CNT_INIT = 8'(MULDIV_LAT - 2);

  logic [1:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       md_done, md_done_nxt;
  logic       stall_inc;
  logic       lu;

  // Load-use hazard: the load in EX writes a register the ID instruction reads (r0 never hazards).
  always_comb begin
    lu = ex_memread && (ex_rd != '0) &&
         ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  end

  // Output qualifiers and next-state decode; everything is held low during Reset and when Tick=0.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    md_done_nxt = md_done;
    stall_inc   = 1'b0;
    if (!Reset) begin
      halted = (state == HALTED);
      if (Tick) begin
        case (state)
          RUN: begin
            md_done_nxt = 1'b0;
            if (ex_branch_taken) begin
              pc_en      = 1'b1;
              ifid_en    = 1'b1;
              idex_en    = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (ex_muldiv && !md_done) begin
              exmem_en    = 1'b1;
              memwb_en    = 1'b1;
              exmem_flush = 1'b1;
              cnt_nxt     = MD_CNT_INIT;
              state_nxt   = MD_BUSY;
              stall_inc   = 1'b1;
            end else if (lu) begin
              idex_en    = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
              idex_flush = 1'b1;
              stall_inc  = 1'b1;
            end else if (halt_req) begin
              idex_en    = 1'b1;
              exmem_en   = 1'b1;
              memwb_en   = 1'b1;
              idex_flush = 1'b1;
              cnt_nxt    = 8'd1;
              state_nxt  = DRAIN;
            end else begin
              pc_en    = 1'b1;
              ifid_en  = 1'b1;
              idex_en  = 1'b1;
              exmem_en = 1'b1;
              memwb_en = 1'b1;
            end
          end
          MD_BUSY: begin
            // Branch and halt requests wait until the mul/div result has left EX.
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            exmem_flush = 1'b1;
            stall_inc   = 1'b1;
            if (cnt == 8'd0) begin
              state_nxt   = RUN;
              md_done_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt - 8'd1;
            end
          end
          DRAIN: begin
            // IF/ID is frozen so the next instruction survives the halt.
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
            if (cnt == 8'd0) begin
              state_nxt = HALTED;
            end else begin
              cnt_nxt = cnt - 8'd1;
            end
          end
          default: begin
            if (!halt_req) begin
              state_nxt = RUN;
            end
          end
        endcase
      end
    end
  end

  // FSM, countdown and mul/div completion flag advance only on Tick.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= RUN;
      cnt     <= 8'd0;
      md_done <= 1'b0;
    end else if (Tick) begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      md_done <= md_done_nxt;
    end
  end

  // Saturating hazard stall counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_count <= '0;
    end else if (Tick && stall_inc && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench for pipeline_stall_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A narrow stall counter is used so saturation is reachable in a few cycles.
module tb_pipeline_stall_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Tick;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken, ex_muldiv, halt_req;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, halted;
  logic [3:0] stall_count;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, halted}
  localparam logic [8:0] V_OFF  = 9'b000000000;
  localparam logic [8:0] V_RUN  = 9'b111110000;
  localparam logic [8:0] V_LU   = 9'b001110100;
  localparam logic [8:0] V_MD   = 9'b000110010;
  localparam logic [8:0] V_BR   = 9'b111111100;
  localparam logic [8:0] V_HALT = 9'b000000001;

  pipeline_stall_ctrl #(
    .REG_ADDR_W (5),
    .MULDIV_LAT (8),
    .STALL_CNT_W(4)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Tick           (Tick),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_memread     (ex_memread),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_muldiv      (ex_muldiv),
    .halt_req       (halt_req),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .halted         (halted),
    .stall_count    (stall_count)
  );

  always #5 Clock = ~Clock;

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; ex_muldiv = 1'b0; halt_req = 1'b0;
  endtask

  task automatic set_lu_rs(input logic [4:0] rd, input logic [4:0] rs);
    ex_memread = 1'b1; ex_rd = rd; id_rs = rs; id_uses_rs = 1'b1;
  endtask

  // Check the current cycle's outputs and counter, then advance past the next edge.
  task automatic cyc(input string tag, input logic [8:0] exp_v, input logic [3:0] exp_cnt);
    @(negedge Clock);
    check({tag, ".outs"}, 32'(outs), 32'(exp_v));
    check({tag, ".cnt"}, 32'(stall_count), 32'(exp_cnt));
    @(posedge Clock);
    #1;
  endtask

  initial begin
    clear_inputs();
    Tick  = 1'b1;
    Reset = 1'b1;
    #2;
    check("reset.outs", 32'(outs), 32'(V_OFF));
    check("reset.cnt", 32'(stall_count), 32'd0);
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;

    cyc("idle", V_RUN, 4'd0);
    Tick = 1'b0;
    cyc("tick0", V_OFF, 4'd0);
    Tick = 1'b1;
    cyc("tick1", V_RUN, 4'd0);

    // Load-use on rs, then r0 (no hazard), then rt, then rt match but unused.
    set_lu_rs(5'd5, 5'd5);
    cyc("lu_rs", V_LU, 4'd0);
    clear_inputs();
    cyc("lu_after", V_RUN, 4'd1);
    set_lu_rs(5'd0, 5'd0);
    cyc("lu_r0", V_RUN, 4'd1);
    clear_inputs();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    cyc("lu_rt", V_LU, 4'd1);
    id_uses_rt = 1'b0;
    cyc("lu_rt_unused", V_RUN, 4'd2);
    clear_inputs();

    // Mul/div held: 8 stall cycles then one free cycle with no re-trigger.
    ex_muldiv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("md%0d", i), V_MD, 4'(2 + i));
    end
    cyc("md_done", V_RUN, 4'd10);
    ex_muldiv = 1'b0;
    cyc("md_after", V_RUN, 4'd10);

    // Taken branch overrides a coincident load-use.
    ex_branch_taken = 1'b1;
    set_lu_rs(5'd5, 5'd5);
    cyc("br_lu", V_BR, 4'd10);
    clear_inputs();
    cyc("br_after", V_RUN, 4'd10);

    // Drain and halt, Tick=0 while halted, then release.
    halt_req = 1'b1;
    cyc("halt_entry", V_LU, 4'd10);
    cyc("drain0", V_LU, 4'd10);
    cyc("drain1", V_LU, 4'd10);
    cyc("halted0", V_HALT, 4'd10);
    Tick = 1'b0;
    cyc("halted_tick0", V_HALT, 4'd10);
    Tick = 1'b1;
    cyc("halted1", V_HALT, 4'd10);
    halt_req = 1'b0;
    cyc("halted_release", V_HALT, 4'd10);
    cyc("run_after_halt", V_RUN, 4'd10);

    // Halt request dropped mid-drain still completes with one halted cycle.
    halt_req = 1'b1;
    cyc("halt2_entry", V_LU, 4'd10);
    halt_req = 1'b0;
    cyc("halt2_drain0", V_LU, 4'd10);
    cyc("halt2_drain1", V_LU, 4'd10);
    cyc("halt2_halted", V_HALT, 4'd10);
    cyc("halt2_run", V_RUN, 4'd10);

    // Saturation of the 4-bit counter under continuous load-use.
    set_lu_rs(5'd9, 5'd9);
    for (int i = 0; i < 7; i++) begin
      cyc($sformatf("sat%0d", i), V_LU, 4'((10 + i > 15) ? 15 : 10 + i));
    end
    clear_inputs();
    cyc("sat_after", V_RUN, 4'd15);

    // Asynchronous reset in the third MD_BUSY cycle.
    ex_muldiv = 1'b1;
    cyc("mdr_start", V_MD, 4'd15);
    cyc("mdr_busy1", V_MD, 4'd15);
    cyc("mdr_busy2", V_MD, 4'd15);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset.outs", 32'(outs), 32'(V_OFF));
    check("async_reset.cnt", 32'(stall_count), 32'd0);
    ex_muldiv = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    cyc("post_reset", V_RUN, 4'd0);
    ex_muldiv = 1'b1;
    cyc("post_reset_md", V_MD, 4'd0);
    ex_muldiv = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
